// File: rtl/dw02_mac_seq.sv
// Dot-product sequencer: job setup, streamed MAC, valid/ready result port.
// Optional sticky overflow flag: define DW02_MAC_SEQ_OVF_EN.
module dw02_mac_seq #(
    parameter int A_width   = 8,
    parameter int B_width   = 8,
    parameter int CNT_width = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CNT_width-1:0]       len,
    input  logic                       tc,
    input  logic [A_width+B_width-1:0] acc_init,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_width-1:0]         in_a,
    input  logic [B_width-1:0]         in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_width+B_width-1:0] out_mac
`ifdef DW02_MAC_SEQ_OVF_EN
    ,
    output logic                       ovf
`endif
);

    localparam int W = A_width + B_width;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         acc_q, acc_d;
    logic [CNT_width-1:0] cnt_q, cnt_d;
    logic                 tc_q, tc_d;

    logic [W-1:0] a_e, b_e, prod, sum;
    logic         accept;

    // Sign-extending to the full width makes the low W product bits exact
    // for both signed and unsigned operands.
    assign a_e  = {{B_width{tc_q & in_a[A_width-1]}}, in_a};
    assign b_e  = {{A_width{tc_q & in_b[B_width-1]}}, in_b};
    assign prod = a_e * b_e;
    assign sum  = prod + acc_q;

    assign accept = in_valid && (state_q == RUN);

`ifdef DW02_MAC_SEQ_OVF_EN
    logic         ovf_q, ovf_d, ovf_hit;
    logic [W:0]   sum_x;

    assign sum_x   = {tc_q & prod[W-1], prod} + {tc_q & acc_q[W-1], acc_q};
    assign ovf_hit = tc_q ? (sum_x[W] ^ sum_x[W-1]) : sum_x[W];
    assign ovf     = ovf_q;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tc_d    = tc_q;
`ifdef DW02_MAC_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = acc_init;
                    cnt_d   = len;
                    tc_d    = tc;
`ifdef DW02_MAC_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_q - 1'b1;
`ifdef DW02_MAC_SEQ_OVF_EN
                    if (ovf_hit) ovf_d = 1'b1;
`endif
                    if (cnt_q == CNT_width'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
        end
    end

`ifdef DW02_MAC_SEQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
`endif

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign out_mac   = out_valid ? acc_q : '0;

endmodule
